// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Pipeline stage register with a DATA/CTRL payload split, a
//            valid/ready handshake through a 2-entry skid buffer, synchronous
//            flush and a global stall. Optional stall and bubble counters are
//            built when PIPE_STAGE_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}}
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int                CNT_W    = 32
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_HALF  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_valid;
    logic w_accept;
    logic w_xfer;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_valid  = (r_state != S_EMPTY);
    assign w_accept = valid_i & r_ready;
    assign w_xfer   = w_valid & ready_i & ~stall_i;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush_i) begin
            // Any transfer this cycle still completes downstream; captures are dropped.
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = S_HALF;
                    end
                end
                S_HALF: begin
                    if (w_accept && w_xfer) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = S_FULL;
                    end else if (w_xfer) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_xfer) begin
                        w_load_main_skid = 1'b1;
                        w_state_nxt      = S_HALF;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= S_EMPTY;
            r_ready     <= 1'b0;
            r_main_data <= '0;
            r_main_ctrl <= NOP_CTRL;
            r_skid_data <= '0;
            r_skid_ctrl <= NOP_CTRL;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != S_FULL);
            if (w_load_main_in) begin
                r_main_data <= data_i;
                r_main_ctrl <= ctrl_i;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= data_i;
                r_skid_ctrl <= ctrl_i;
            end
        end
    end

    assign valid_o = w_valid;
    assign ready_o = r_ready;
    assign data_o  = r_main_data;
    assign ctrl_o  = w_valid ? r_main_ctrl : NOP_CTRL;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating counters; flush deliberately has no effect on them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_valid && !w_xfer && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (!w_valid && ready_i && !stall_i && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
`default_nettype wire
